wash_cycle_ctrl: RTL
====================

Name: wash_cycle_ctrl

Overview:
- Top-level cycle sequencer for the washing machine.
- Accepts a coin/start pulse and steps through FILL, WASH, RINSE and SPIN.
- Sits directly upstream of the filling-water counter: drives its start and active-low soft-reset inputs, forwards the latched clock-frequency code, and consumes its done flag.
- Times WASH, RINSE and SPIN internally with one shared phase counter.

Parameters:
- BASE_TICKS, 1000000, clock cycles per second at clk_freq=2'b00 (1 MHz)
- WASH_SEC, 300, WASH phase duration in seconds
- RINSE_SEC, 120, RINSE phase duration in seconds
- SPIN_SEC, 60, SPIN phase duration in seconds

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- coin_in  in  1  single-cycle start request
- abort  in  1  synchronous cancel request
- clk_freq  in  2  clock-rate code: 00=1, 01=2, 10=4, 11=8 MHz
- fill_done  in  1  done flag from the filling-water counter
- start_filling  out  1  filling-counter enable
- fill_soft_rst_n  out  1  filling-counter soft clear (active low)
- fill_clk_freq  out  2  latched clk_freq forwarded to the filling counter
- state  out  3  current phase
- busy  out  1  high in any state other than IDLE
- wash_done  out  1  one-cycle pulse on normal completion

Behaviour:
- One clock domain. Reset is asynchronous and active-high; it is named rst. The clock is named clk.
- State encoding: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4. Values 5-7 are illegal and return to IDLE on the next cycle.
- Reset values:
  - state=IDLE, phase_cnt=0, freq_q=2'b00.
  - start_filling=0, fill_soft_rst_n=0, busy=0, wash_done=0.
- All outputs are registered or decoded directly from state. There is no combinational path from any input to any output.
- IDLE:
  - When coin_in=1, latch freq_q<=clk_freq and go to FILL on the next cycle.
  - clk_freq changes after acceptance are ignored until the next cycle.
- FILL:
  - start_filling=1 and fill_soft_rst_n=1.
  - When fill_done=1, go to WASH on the next cycle.
  - FILL has no internal timeout.
- fill_soft_rst_n=0 in every state except FILL. The filling counter is therefore cleared outside FILL and is ready for the next cycle.
- WASH, RINSE, SPIN:
  - phase_cnt clears to 0 on entry and increments by 1 per cycle.
  - When phase_cnt == stop-1, advance on the next cycle: WASH->RINSE, RINSE->SPIN, SPIN->IDLE.
  - Each phase therefore lasts exactly stop cycles.
- Stop value: stop = BASE_TICKS * X_SEC << freq_q, where X_SEC is WASH_SEC, RINSE_SEC or SPIN_SEC.
  - Computed in 32-bit unsigned arithmetic.
  - Parameters must keep stop < 2^32 for freq_q=3 and stop >= 1.
- wash_done: 1 for exactly the cycle in which state becomes IDLE after SPIN completes.
- abort=1 in any non-IDLE state: go to IDLE on the next cycle, phase_cnt<=0, no wash_done pulse.
- abort and coin_in together in IDLE: abort wins and the coin is ignored.
- coin_in while busy: ignored.
- fill_clk_freq = freq_q at all times.
- Reset asserted mid-cycle: immediate return to reset values. No wash_done pulse.

Optional Feature:
- Macro: WASH_TIMER_PAUSE_EN.
- When defined:
  - Adds input pause (1 bit).
  - While pause=1 in WASH, RINSE or SPIN, phase_cnt holds and no transition occurs.
  - While pause=1 in FILL, start_filling=0. fill_soft_rst_n stays 1, so the fill count is preserved.
  - abort still overrides pause.
- When undefined: the port is absent and phases are never frozen.

Decomposition:
- Shared package wash_pkg holds:
  - state encoding localparams (IDLE, FILL, WASH, RINSE, SPIN)
  - the clk_freq code constants
  - the 32-bit count width constant
- One natural sub-module, phase_timer: 32-bit counter with clear, enable and stop-compare, producing the last-cycle flag.

Test Plan:
All scenarios use BASE_TICKS=1, WASH_SEC=5, RINSE_SEC=3, SPIN_SEC=2.
- Full cycle, clk_freq=01:
  - Stimulus: coin pulse at cycle 0; fill_done at cycle 4.
  - Response: FILL during cycles 1-4. WASH for 10 cycles, RINSE for 6 cycles, SPIN for 4 cycles. wash_done high for exactly 1 cycle at IDLE entry; busy low afterwards.
- Frequency latch:
  - Stimulus: coin with clk_freq=11, then clk_freq changed to 00 in FILL.
  - Response: fill_clk_freq stays 11; WASH lasts 40 cycles.
- Abort:
  - Stimulus: abort in cycle 3 of RINSE.
  - Response: IDLE next cycle, wash_done stays 0, fill_soft_rst_n=0.
- Coin in busy/abort contention:
  - Stimulus: coin during WASH, then coin+abort together in IDLE.
  - Response: both ignored; state remains WASH, then remains IDLE.
- Async reset:
  - Stimulus: rst asserted mid-SPIN.
  - Response: all outputs at reset values immediately, without waiting for a clk edge.
- With WASH_TIMER_PAUSE_EN:
  - Stimulus: pause=1 for 7 cycles mid-WASH.
  - Response: WASH occupies 17 cycles in total.

Source files
------------

// File: rtl/wash_cycle_ctrl_pkg.sv
// Shared definitions for the washing-machine cycle sequencer.
//   - state encoding for the phase sequencer
//   - clk_freq code constants (1/2/4/8 MHz)
//   - width of the shared phase counter
//   - calc_stop(): converts a phase length in seconds into a clock-cycle count
package wash_pkg;

    localparam int CNT_W = 32;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] WASH  = 3'd2;
    localparam logic [2:0] RINSE = 3'd3;
    localparam logic [2:0] SPIN  = 3'd4;

    localparam logic [1:0] FREQ_1MHZ = 2'b00;
    localparam logic [1:0] FREQ_2MHZ = 2'b01;
    localparam logic [1:0] FREQ_4MHZ = 2'b10;
    localparam logic [1:0] FREQ_8MHZ = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = 32'd1;

    // Cycles per phase: ticks-per-second at 1 MHz times seconds, scaled by the
    // clock-rate code (each code step doubles the clock rate).
    function automatic logic [CNT_W-1:0] calc_stop(input logic [CNT_W-1:0] base,
                                                   input logic [CNT_W-1:0] secs,
                                                   input logic [1:0]       code);
        logic [CNT_W-1:0] prod;
        prod = base * secs;
        return prod << code;
    endfunction

endpackage

// File: rtl/wash_cycle_ctrl_if.sv
// Control/status bundle between the cycle sequencer and its environment.
//   master : drives coin_in, abort, clk_freq, fill_done (and pause when
//            WASH_TIMER_PAUSE_EN is defined); observes all sequencer outputs
//   slave  : the sequencer itself (wash_cycle_ctrl)
// Optional macro: WASH_TIMER_PAUSE_EN adds the pause request line.
interface wash_cycle_ctrl_if;

    logic       coin_in;
    logic       abort;
    logic [1:0] clk_freq;
    logic       fill_done;
`ifdef WASH_TIMER_PAUSE_EN
    logic       pause;
`endif
    logic       start_filling;
    logic       fill_soft_rst_n;
    logic [1:0] fill_clk_freq;
    logic [2:0] state;
    logic       busy;
    logic       wash_done;

    modport master (
        output coin_in, abort, clk_freq, fill_done,
`ifdef WASH_TIMER_PAUSE_EN
        output pause,
`endif
        input  start_filling, fill_soft_rst_n, fill_clk_freq, state, busy, wash_done
    );

    modport slave (
        input  coin_in, abort, clk_freq, fill_done,
`ifdef WASH_TIMER_PAUSE_EN
        input  pause,
`endif
        output start_filling, fill_soft_rst_n, fill_clk_freq, state, busy, wash_done
    );

endinterface

// File: rtl/wash_cycle_ctrl_phase_timer.sv
// Shared phase counter for the timed phases (WASH, RINSE, SPIN).
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clear    : synchronous clear to 0 (priority over en)
//   en       : count one per cycle
//   stop     : phase length in cycles (>= 1)
//   last     : high while counting in the final cycle of the phase
module phase_timer
    import wash_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] stop,
    output logic             last
);

    logic [CNT_W-1:0] phase_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
        end else if (clear) begin
            phase_cnt <= '0;
        end else if (en) begin
            phase_cnt <= phase_cnt + CNT_ONE;
        end
    end

    // Gated by en so a frozen phase never reports completion.
    assign last = en && (phase_cnt == (stop - CNT_ONE));

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: IDLE -> FILL -> WASH -> RINSE -> SPIN -> IDLE.
// Drives the filling-water counter (start_filling, fill_soft_rst_n,
// fill_clk_freq) and consumes its fill_done flag; WASH/RINSE/SPIN are timed
// by one shared phase_timer.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : wash_cycle_ctrl_if.slave (coin_in, abort, clk_freq, fill_done
//          in; start_filling, fill_soft_rst_n, fill_clk_freq, state, busy,
//          wash_done out)
// Optional macro: WASH_TIMER_PAUSE_EN adds bus.pause, which freezes the
// timed phases and suspends filling without clearing the fill count.
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int unsigned BASE_TICKS = 1000000,
    parameter int unsigned WASH_SEC   = 300,
    parameter int unsigned RINSE_SEC  = 120,
    parameter int unsigned SPIN_SEC   = 60
)
(
    input  logic             clk,
    input  logic             rst,
    wash_cycle_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] BASE_W  = 32'(BASE_TICKS);
    localparam logic [CNT_W-1:0] WASH_W  = 32'(WASH_SEC);
    localparam logic [CNT_W-1:0] RINSE_W = 32'(RINSE_SEC);
    localparam logic [CNT_W-1:0] SPIN_W  = 32'(SPIN_SEC);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [1:0]       freq_q;
    logic             wash_done_q;
    logic             accept;
    logic             finish;
    logic             timed;
    logic             paused;
    logic             fill_hold;
    logic             phase_last;
    logic [CNT_W-1:0] stop_sel;

`ifdef WASH_TIMER_PAUSE_EN
    logic pause_q;

    assign paused    = bus.pause;
    // Registered so start_filling never depends combinationally on an input.
    assign fill_hold = pause_q;
`else
    assign paused    = 1'b0;
    assign fill_hold = 1'b0;
`endif

    assign timed = (state_q == WASH) || (state_q == RINSE) || (state_q == SPIN);

    always_comb begin
        stop_sel = calc_stop(BASE_W, WASH_W, freq_q);
        case (state_q)
            RINSE:   stop_sel = calc_stop(BASE_W, RINSE_W, freq_q);
            SPIN:    stop_sel = calc_stop(BASE_W, SPIN_W, freq_q);
            default: stop_sel = calc_stop(BASE_W, WASH_W, freq_q);
        endcase
    end

    // Any state change restarts the counter, so each timed phase starts at 0
    // and an abort leaves it cleared.
    phase_timer u_phase_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_d != state_q),
        .en    (timed && !paused),
        .stop  (stop_sel),
        .last  (phase_last)
    );

    // State register (also holds the latched frequency and the done pulse)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            freq_q      <= FREQ_1MHZ;
            wash_done_q <= 1'b0;
`ifdef WASH_TIMER_PAUSE_EN
            pause_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wash_done_q <= finish;
            if (accept) begin
                freq_q <= bus.clk_freq;
            end
`ifdef WASH_TIMER_PAUSE_EN
            pause_q     <= paused;
`endif
        end
    end

    // Next-state logic; abort always has priority over coin, fill_done and
    // the phase timer.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.coin_in && !bus.abort) begin
                    accept  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.abort)          state_d = IDLE;
                else if (bus.fill_done) state_d = WASH;
            end
            WASH: begin
                if (bus.abort)       state_d = IDLE;
                else if (phase_last) state_d = RINSE;
            end
            RINSE: begin
                if (bus.abort)       state_d = IDLE;
                else if (phase_last) state_d = SPIN;
            end
            SPIN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (phase_last) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        bus.state           = state_q;
        bus.busy            = (state_q != IDLE);
        bus.fill_soft_rst_n = (state_q == FILL);
        bus.start_filling   = (state_q == FILL) && !fill_hold;
        bus.fill_clk_freq   = freq_q;
        bus.wash_done       = wash_done_q;
    end

endmodule
